// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: uop enums, the decoded control entry and the
// default issue-queue depth.
package rv32i_types;

  localparam int IQ_DEPTH = 8;

  typedef enum logic [3:0] {
    UOPC_ADD, UOPC_ADDI, UOPC_SUB, UOPC_AND, UOPC_OR, UOPC_XOR,
    UOPC_LUI, UOPC_LW, UOPC_SW, UOPC_BEQ, UOPC_JAL, UOPC_NOP
  } uopc_t;

  typedef enum logic [1:0] {EXUT_ALU, EXUT_LSU, EXUT_BRU, EXUT_NONE} exut_t;

  typedef enum logic [2:0] {IMMT_NONE, IMMT_I, IMMT_S, IMMT_B, IMMT_U, IMMT_J} immt_t;

  typedef struct packed {
    uopc_t       uopcode;
    exut_t       exu_type;
    logic        has_rd;
    logic        has_rs1;
    logic        has_rs2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    immt_t       imm_type;
    logic [19:0] packed_imm;
  } ctrl_entry_t;

endpackage

// File: rtl/issue_queue_if.sv
// Decode/issue/writeback bundle around the issue queue; busy is a read-only
// view of the register scoreboard.
interface issue_queue_if import rv32i_types::*; #(parameter int DEPTH = IQ_DEPTH);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens in a cycle where valid && ready at the
  // rising edge; valid never depends on ready, enq_ready depends only on count.
  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  ctrl_entry_t   enq_uop;
  logic          deq_valid;
  logic          deq_ready;
  ctrl_entry_t   deq_uop;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [CW-1:0] count;
  logic [31:0]   busy;

  modport master (
    output flush, enq_valid, enq_uop, deq_ready, wb_valid, wb_rd,
    input  enq_ready, deq_valid, deq_uop, count, busy
  );

  modport slave (
    input  flush, enq_valid, enq_uop, deq_ready, wb_valid, wb_rd,
    output enq_ready, deq_valid, deq_uop, count, busy
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Register busy vector: set on issue, cleared on writeback, head readiness test.
// Define ISSUE_WB_BYPASS_EN to let a same-cycle writeback unblock the head.
module issue_scoreboard import rv32i_types::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        issue_i,
  input  ctrl_entry_t head_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  output logic        head_ready_o,
  output logic [31:0] busy_o
);

  logic [31:0] busy_q, busy_d;
  logic [31:0] bypass_mask;
  logic [31:0] eff_busy;

`ifdef ISSUE_WB_BYPASS_EN
  assign bypass_mask = wb_valid_i ? (32'd1 << wb_rd_i) : 32'd0;
`else
  assign bypass_mask = 32'd0;
`endif

  assign eff_busy = busy_q & ~bypass_mask;

  // WAW is checked too: a busy destination blocks issue.
  assign head_ready_o = (!head_i.has_rs1 || !eff_busy[head_i.rs1]) &&
                        (!head_i.has_rs2 || !eff_busy[head_i.rs2]) &&
                        (!head_i.has_rd  || !eff_busy[head_i.rd]);

  // Clear before set so a same-register issue/writeback leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
      if (issue_i && head_i.has_rd && (head_i.rd != 5'd0)) busy_d[head_i.rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: circular FIFO of decoded uops, head-only issue gated
// by issue_scoreboard. Optional ISSUE_WB_BYPASS_EN is handled in the scoreboard.
module issue_queue import rv32i_types::*; #(parameter int DEPTH = IQ_DEPTH) (
  input logic          clk,
  input logic          rst,
  issue_queue_if.slave io
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ctrl_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty;
  logic          enq_fire, deq_fire;
  logic          head_ready;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign enq_fire = io.enq_valid && !full;
  assign deq_fire = io.deq_valid && io.deq_ready;

  assign io.enq_ready = !full;
  assign io.deq_valid = !empty && head_ready;
  assign io.deq_uop   = mem_q[rd_ptr_q];
  assign io.count     = count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (io.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= io.enq_uop;
  end

  issue_scoreboard u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (io.flush),
    .issue_i      (deq_fire),
    .head_i       (io.deq_uop),
    .wb_valid_i   (io.wb_valid),
    .wb_rd_i      (io.wb_rd),
    .head_ready_o (head_ready),
    .busy_o       (io.busy)
  );

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue against a queue-based reference model.
// Build with ISSUE_WB_BYPASS_EN defined to check the bypass variant.
module tb_issue_queue;
  import rv32i_types::*;

  localparam int DEPTH = IQ_DEPTH;
  localparam int W     = $bits(ctrl_entry_t);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   check_on;

  logic [W-1:0] exp_q[$];
  logic [31:0]  m_busy;

  issue_queue_if #(.DEPTH(DEPTH)) io ();
  issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .io(io));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ctrl_entry_t mk(input uopc_t op, input logic hrd, input int rd,
                                     input logic hs1, input int rs1, input logic hs2, input int rs2);
    ctrl_entry_t u;
    u.uopcode    = op;
    u.exu_type   = EXUT_ALU;
    u.has_rd     = hrd;
    u.has_rs1    = hs1;
    u.has_rs2    = hs2;
    u.rd         = 5'(rd);
    u.rs1        = 5'(rs1);
    u.rs2        = 5'(rs2);
    u.imm_type   = (op == UOPC_ADDI) ? IMMT_I : IMMT_NONE;
    u.packed_imm = 20'($urandom);
    return u;
  endfunction

  function automatic ctrl_entry_t rnd_uop();
    ctrl_entry_t u;
    u.uopcode    = uopc_t'($urandom_range(0, 11));
    u.exu_type   = exut_t'($urandom_range(0, 3));
    u.has_rd     = 1'($urandom_range(0, 1));
    u.has_rs1    = 1'($urandom_range(0, 1));
    u.has_rs2    = 1'($urandom_range(0, 1));
    u.rd         = 5'($urandom_range(0, 3));
    u.rs1        = 5'($urandom_range(0, 3));
    u.rs2        = 5'($urandom_range(0, 3));
    u.imm_type   = immt_t'($urandom_range(0, 5));
    u.packed_imm = 20'($urandom);
    return u;
  endfunction

  // driver: one clock cycle of stimulus, output checks, then model advance
  task automatic cyc(input logic r, input logic f, input logic ev, input ctrl_entry_t u,
                     input logic dr, input logic wv, input int wr);
    ctrl_entry_t h;
    logic [31:0] eb;
    logic        exp_dv, exp_er, dfire, efire;
    @(negedge clk);
    rst          = r;
    io.flush     = f;
    io.enq_valid = ev;
    io.enq_uop   = u;
    io.deq_ready = dr;
    io.wb_valid  = wv;
    io.wb_rd     = 5'(wr);
    #1;
    h  = '0;
    if (exp_q.size() > 0) h = ctrl_entry_t'(exp_q[0]);
    eb = m_busy;
`ifdef ISSUE_WB_BYPASS_EN
    if (wv) eb[wr] = 1'b0;
`endif
    exp_dv = (exp_q.size() > 0) && !(h.has_rs1 && eb[h.rs1]) &&
             !(h.has_rs2 && eb[h.rs2]) && !(h.has_rd && eb[h.rd]);
    exp_er = (exp_q.size() < DEPTH);
    if (check_on) begin
      chk("enq_ready", 64'(io.enq_ready), 64'(exp_er));
      chk("count", 64'(io.count), 64'(exp_q.size()));
      chk("deq_valid", 64'(io.deq_valid), 64'(exp_dv));
      chk("busy", 64'(io.busy), 64'(m_busy));
      if (exp_dv) chk("deq_uop", 64'(io.deq_uop), 64'(h));
    end
    dfire = exp_dv && dr;
    efire = ev && exp_er;
    if (r || f) begin
      exp_q.delete();
      m_busy = '0;
    end else begin
      if (dfire) void'(exp_q.pop_front());
      if (wv) m_busy[wr] = 1'b0;
      if (dfire && h.has_rd && h.rd != 5'd0) m_busy[h.rd] = 1'b1;
      if (efire) exp_q.push_back(W'(u));
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic idle(input logic dr);
    cyc(1'b0, 1'b0, 1'b0, '0, dr, 1'b0, 0);
  endtask

  initial begin
    ctrl_entry_t nop;
    n_checks = 0;
    n_fail   = 0;
    check_on = 1'b0;
    m_busy   = '0;
    rst = 1'b1; io.flush = 1'b0; io.enq_valid = 1'b0; io.enq_uop = '0;
    io.deq_ready = 1'b0; io.wb_valid = 1'b0; io.wb_rd = '0;
    nop = mk(UOPC_NOP, 1'b0, 0, 1'b0, 0, 1'b0, 0);

    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0);
    check_on = 1'b1;

    // reset state, then ADDI x5 <- x0 enqueued in cycle 0
    cyc(1'b0, 1'b0, 1'b1, mk(UOPC_ADDI, 1'b1, 5, 1'b1, 0, 1'b0, 0), 1'b1, 1'b0, 0);
    chk("rst_count", 64'(io.count), 64'd0);
    chk("rst_enq_ready", 64'(io.enq_ready), 64'd1);
    chk("rst_deq_valid", 64'(io.deq_valid), 64'd0);
    idle(1'b1);
    chk("addi_deq_valid_c1", 64'(io.deq_valid), 64'd1);
    // ADD x6 <- x5 waits on busy x5
    cyc(1'b0, 1'b0, 1'b1, mk(UOPC_ADD, 1'b1, 6, 1'b1, 5, 1'b0, 0), 1'b1, 1'b0, 0);
    chk("addi_busy5_c2", 64'(io.busy[5]), 64'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("add_held", 64'(io.deq_valid), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 5);
    for (int i = 0; i < 2; i++) idle(1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 6);
    idle(1'b1);

    // fill to DEPTH with deq_ready low, then one issue while offering more
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, rnd_uop() & ~W'(0) & nop | nop, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, nop, 1'b1, 1'b0, 0);
    chk("full_count", 64'(io.count), 64'(DEPTH));
    chk("full_enq_ready", 64'(io.enq_ready), 64'd0);
    idle(1'b0);
    chk("after_issue_count", 64'(io.count), 64'(DEPTH - 1));
    chk("after_issue_enq_ready", 64'(io.enq_ready), 64'd1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // rd=0 write then a reader of x0: back-to-back issue, busy stays zero
    cyc(1'b0, 1'b0, 1'b1, mk(UOPC_ADDI, 1'b1, 0, 1'b1, 0, 1'b0, 0), 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, mk(UOPC_ADD, 1'b1, 3, 1'b1, 0, 1'b1, 0), 1'b1, 1'b0, 0);
    idle(1'b1);
    chk("x0_second_issue", 64'(io.deq_valid), 64'd1);
    chk("x0_busy_zero_after_first", 64'(io.busy[0]), 64'd0);
    idle(1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 3);

    // flush with 3 queued, a busy bit set, plus enq and wb in the same cycle
    cyc(1'b0, 1'b0, 1'b1, mk(UOPC_ADDI, 1'b1, 7, 1'b0, 0, 1'b0, 0), 1'b1, 1'b0, 0);
    idle(1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, rnd_uop(), 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b1, nop, 1'b1, 1'b1, 7);
    idle(1'b1);
    chk("flush_count", 64'(io.count), 64'd0);
    chk("flush_busy", 64'(io.busy), 64'd0);
    chk("flush_deq_valid", 64'(io.deq_valid), 64'd0);

    // 20 enqueue/issue pairs with deq_ready toggling: order via deq_uop checks
    for (int i = 0; i < 44; i++) begin
      ctrl_entry_t u;
      u = rnd_uop();
      u.has_rd = 1'b0; u.has_rs1 = 1'b0; u.has_rs2 = 1'b0;
      cyc(1'b0, 1'b0, (i < 20), u, 1'(i % 2), 1'b0, 0);
    end
    chk("wrap_drained", 64'(io.count), 64'd0);

    // randomized traffic with hazards, rare flush and mid-run reset
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 1)), rnd_uop(), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)));
    end

    // reset mid-operation together with flush and handshakes
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, rnd_uop(), 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b1, rnd_uop(), 1'b1, 1'b1, 2);
    idle(1'b0);
    chk("rst_mid_count", 64'(io.count), 64'd0);
    chk("rst_mid_busy", 64'(io.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8 (power of two, >=2), the number of queue entries.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port flush  input  1  discard all queued uops and clear all busy bits.
REQ-005 SHALL have port enq_valid  input  1  decode offers a uop.
REQ-006 SHALL have port enq_ready  output  1  queue accepts the uop; equals not-full, with no combinational dependence on deq or wb.
REQ-007 SHALL have port enq_uop  input  ctrl_entry_t  decoded uop: uopcode, exu_type, has_rd/rs1/rs2, rd/rs1/rs2 (5 each), imm_type, packed_imm (20).
REQ-008 SHALL have port deq_valid  output  1  head uop is issuable this cycle.
REQ-009 SHALL have port deq_ready  input  1  execute/register-read stage takes the uop.
REQ-010 SHALL have port deq_uop  output  ctrl_entry_t  head entry contents.
REQ-011 SHALL have port wb_valid  input  1  a writeback retires a destination.
REQ-012 SHALL have port wb_rd  input  5  register written back.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 SHALL be an in-order FIFO: enqueue on enq_valid && enq_ready; issue on deq_valid && deq_ready; head-only issue.
REQ-015 SHALL keep a 32-bit busy vector; bit 0 SHALL always read 0 and never be set.
REQ-016 SHALL assert deq_valid iff queue non-empty and, for the head: (!has_rs1 || !busy[rs1]) && (!has_rs2 || !busy[rs2]) && (!has_rd || !busy[rd]).
REQ-017 SHALL set busy[rd] on issue when has_rd && rd!=0, visible the next cycle.
REQ-018 SHALL clear busy[wb_rd] on wb_valid, visible the next cycle (see REQ-027 for bypass).
REQ-019 SHALL, when issue sets and wb clears the same register in one cycle, leave the bit set.
REQ-020 SHALL have enqueue-to-issue latency of at least 1 cycle: an entry enqueued in cycle N is earliest deq_valid in cycle N+1.
REQ-021 SHALL, when full, deassert enq_ready even if an issue occurs that cycle; when full and issuing, count drops by 1.
REQ-022 SHALL, when empty, hold deq_valid low; deq_uop is don't-care.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; full/empty derived from count.
REQ-024 SHALL, on flush, next cycle have count=0 and busy all zero; a same-cycle enqueue, issue, or wb is discarded (flush wins).

Reset
REQ-025 SHALL on rst reach the next-cycle state count=0, busy=0, pointers=0, enq_ready=1, deq_valid=0; rst mid-operation discards all entries identically to flush.
REQ-026 SHALL give rst priority over flush and all handshakes.

Configuration
REQ-027 SHALL, with ISSUE_WB_BYPASS_EN defined, treat wb_rd as not busy in the same-cycle REQ-016 check (wb combinationally bypasses the readiness test); without it, a stalled head issues no earlier than the cycle after wb_valid.

Structure
REQ-028 SHALL define ctrl_entry_t and the DEPTH default constant in shared package rv32i_types, reusing uopc, exut and immt enums.
REQ-029 SHALL implement the busy vector and its set/clear/bypass logic as sub-module issue_scoreboard; FIFO storage and pointers stay in issue_queue.

Verification
REQ-030 SHALL cover: reset, then enqueue ADDI rd=5 rs1=0 with deq_ready=1 -> deq_valid in cycle 1; busy[5]=1 in cycle 2.
REQ-031 SHALL cover: ADD rd=6 rs1=5 queued behind ADDI x5 -> held until wb_valid wb_rd=5; issue occurs the same cycle with bypass, one cycle later without.
REQ-032 SHALL cover: fill 8 entries with deq_ready=0 -> enq_ready=0, count=8; one issue -> count=7, enq_ready=1 the next cycle.
REQ-033 SHALL cover: uop with rd=0 issued -> busy stays all zero; a following uop reading x0 issues back-to-back.
REQ-034 SHALL cover: flush asserted with 3 entries, enq_valid=1 and wb_valid=1 -> next cycle count=0, busy=0, deq_valid=0.
REQ-035 SHALL cover: wrap-around after 20 enqueue/issue pairs with deq_ready toggling -> issue order exactly matches enqueue order.
